// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - per-frame shape/color analysis pass sequencer
// Freezes the frame buffer, runs the engine under a watchdog, latches its result.
module proc_sequencer #(
  parameter int FREEZE_CYC = 4,
  parameter int CLR_CYC    = 2,
  parameter int TO_W       = 20,
  parameter int TO_CYC     = 200000,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start,
  input  logic             cmd_continuous,
  input  logic             cmd_abort,
  input  logic             cap_frame_done,
  output logic             cap_freeze,
  output logic             proc_init,
  input  logic             proc_done,
  input  logic [1:0]       proc_color,
  input  logic [1:0]       proc_figure,
  output logic [1:0]       res_color,
  output logic [1:0]       res_figure,
  output logic             res_valid,
  output logic             res_new,
  output logic [CNT_W-1:0] res_count,
  output logic             busy,
  output logic             timeout_err,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FRAME = 3'd1,
    S_FREEZE     = 3'd2,
    S_RUN        = 3'd3,
    S_LATCH      = 3'd4,
    S_RELEASE    = 3'd5
  } state_t;

  localparam logic [TO_W-1:0] FREEZE_LAST = TO_W'(FREEZE_CYC - 1);
  localparam logic [TO_W-1:0] CLR_LAST    = TO_W'(CLR_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TO_CYC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] cnt;
  logic            armed;
  logic            do_latch;
  logic            do_timeout;

  // One counter serves as freeze delay, watchdog and release delay; it restarts on every state change.
  always_comb begin
    state_nxt  = state;
    do_latch   = 1'b0;
    do_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_start) state_nxt = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (cmd_abort)           state_nxt = S_RELEASE;
        else if (cap_frame_done) state_nxt = S_FREEZE;
      end
      S_FREEZE: begin
        if (cmd_abort)               state_nxt = S_RELEASE;
        else if (cnt == FREEZE_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cmd_abort) begin
          state_nxt = S_RELEASE;
        end else if (cnt == TO_LAST) begin
          do_timeout = 1'b1;
          state_nxt  = S_RELEASE;
        end else if (armed && proc_done) begin
          do_latch  = 1'b1;
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (cnt == CLR_LAST) state_nxt = cmd_continuous ? S_WAIT_FRAME : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      armed       <= 1'b0;
      res_color   <= 2'd0;
      res_figure  <= 2'd0;
      res_valid   <= 1'b0;
      res_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + TO_W'(1);
      // A done level left over from the previous run must fall before it can count.
      armed <= (state == S_RUN) && (state_nxt == S_RUN) && (armed || !proc_done);
      if (state == S_IDLE && cmd_start) begin
        res_valid   <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (do_timeout) timeout_err <= 1'b1;
      if (do_latch) begin
        res_color  <= proc_color;
        res_figure <= proc_figure;
        res_valid  <= 1'b1;
        res_count  <= res_count + CNT_W'(1);
      end
    end
  end

  assign cap_freeze = (state == S_FREEZE) || (state == S_RUN) || (state == S_LATCH);
  assign proc_init  = (state == S_RUN);
  assign res_new    = (state == S_LATCH);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - self-checking bench for proc_sequencer
// Cycle model of the pass sequence plus directed scenarios with literal expectations.
module tb_proc_sequencer;
  localparam int FREEZE_CYC = 4;
  localparam int CLR_CYC    = 2;
  localparam int TO_CYC     = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_start = 1'b0, cmd_continuous = 1'b0, cmd_abort = 1'b0, cap_frame_done = 1'b0;
  logic       proc_done = 1'b0;
  logic [1:0] proc_color = 2'd0, proc_figure = 2'd0;
  logic       cap_freeze, proc_init, res_valid, res_new, busy, timeout_err;
  logic [1:0] res_color, res_figure;
  logic [7:0] res_count;
  logic [2:0] state_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  proc_sequencer #(.FREEZE_CYC(FREEZE_CYC), .CLR_CYC(CLR_CYC), .TO_W(20), .TO_CYC(TO_CYC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_continuous(cmd_continuous),
    .cmd_abort(cmd_abort), .cap_frame_done(cap_frame_done), .cap_freeze(cap_freeze),
    .proc_init(proc_init), .proc_done(proc_done), .proc_color(proc_color),
    .proc_figure(proc_figure), .res_color(res_color), .res_figure(res_figure),
    .res_valid(res_valid), .res_new(res_new), .res_count(res_count), .busy(busy),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase name, countdowns and run-cycle count, advanced each rising edge.
  int  m_state = 0, m_left = 0, m_run = 0, m_count = 0;
  bit  m_armed = 0, m_valid = 0, m_terr = 0, started = 0;
  int  m_color = 0, m_fig = 0;

  task automatic m_release();
    m_state = 5;
    m_left  = CLR_CYC;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      started = 1; m_state = 0; m_count = 0; m_valid = 0; m_terr = 0; m_color = 0; m_fig = 0;
    end else if (started) begin
      case (m_state)
        0: if (cmd_start) begin m_state = 1; m_valid = 0; m_terr = 0; end
        1: if (cmd_abort) m_release();
           else if (cap_frame_done) begin m_state = 2; m_left = FREEZE_CYC; end
        2: if (cmd_abort) m_release();
           else begin
             m_left--;
             if (m_left == 0) begin m_state = 3; m_run = 0; m_armed = 0; end
           end
        3: if (cmd_abort) m_release();
           else if (m_run == TO_CYC - 1) begin m_terr = 1; m_release(); end
           else if (m_armed && proc_done) begin
             m_state = 4; m_color = proc_color; m_fig = proc_figure; m_valid = 1;
             m_count = (m_count + 1) % 256;
           end else begin
             m_run++;
             if (!proc_done) m_armed = 1;
           end
        4: m_release();
        default: begin
          m_left--;
          if (m_left == 0) m_state = cmd_continuous ? 1 : 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("state_dbg", state_dbg, m_state);
      check("cap_freeze", cap_freeze, (m_state >= 2 && m_state <= 4));
      check("proc_init", proc_init, (m_state == 3));
      check("res_new", res_new, (m_state == 4));
      check("busy", busy, (m_state != 0));
      check("res_valid", res_valid, m_valid);
      check("timeout_err", timeout_err, m_terr);
      check("res_color", res_color, m_color);
      check("res_figure", res_figure, m_fig);
      check("res_count", res_count, m_count);
    end
  end

  // Continuous-mode monitor: busy must stay high and proc_init must idle between runs.
  bit mon_en = 0, had_run = 0, prev_pi = 0;
  int busy_low = 0, gap = 0, min_gap = 1000;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!busy) busy_low++;
      if (proc_init) begin
        if (had_run && !prev_pi && gap < min_gap) min_gap = gap;
        had_run = 1;
        gap = 0;
      end else gap++;
      prev_pi = proc_init;
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return proc_init;
      1: return res_new;
      2: return busy;
      3: return cap_freeze;
      default: return (state_dbg == 3'd1);
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic val, input int max, input string name);
    int i = 0;
    while (sig(sel) !== val && i < max) begin
      @(negedge clk);
      i++;
    end
    check(name, sig(sel), val);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int sel);
    case (sel)
      0: cmd_start = 1'b1;
      1: cap_frame_done = 1'b1;
      default: cmd_abort = 1'b1;
    endcase
    @(negedge clk);
    cmd_start = 1'b0; cap_frame_done = 1'b0; cmd_abort = 1'b0;
  endtask

  initial begin
    int n;
    cyc(2);
    rst = 1'b0;
    check("rst_state", state_dbg, 0);
    check("rst_busy", busy, 0);
    check("rst_count", res_count, 0);
    check("rst_init", proc_init, 0);

    // 1: basic pass, freeze precedes init by 4 cycles
    pulse(0);
    cyc(10);
    pulse(1);
    wait_until(3, 1'b1, 5, "t1_freeze_up");
    n = 0;
    while (!proc_init && n < 20) begin n++; @(negedge clk); end
    check("t1_freeze_cycles", n, 4);
    cyc(50);
    proc_color = 2'd2; proc_figure = 2'd1; proc_done = 1'b1;
    wait_until(1, 1'b1, 5, "t1_res_new");
    proc_done = 1'b0;
    @(negedge clk);
    check("t1_res_new_pulse", res_new, 0);
    wait_until(2, 1'b0, 10, "t1_idle");
    check("t1_color", res_color, 2);
    check("t1_figure", res_figure, 1);
    check("t1_count", res_count, 1);
    check("t1_valid", res_valid, 1);

    // 2: done stuck high at RUN entry must not latch
    proc_color = 2'd3; proc_figure = 2'd3; proc_done = 1'b1;
    pulse(0);
    pulse(1);
    wait_until(0, 1'b1, 10, "t2_run");
    cyc(5);
    check("t2_no_early_latch", res_count, 1);
    proc_done = 1'b0;
    cyc(3);
    proc_done = 1'b1;
    wait_until(1, 1'b1, 5, "t2_res_new");
    proc_done = 1'b0;
    wait_until(2, 1'b0, 10, "t2_idle");
    check("t2_count", res_count, 2);
    check("t2_color", res_color, 3);

    // 3: watchdog timeout after 100 RUN cycles
    pulse(0);
    pulse(1);
    wait_until(0, 1'b1, 10, "t3_run");
    n = 0;
    while (proc_init && n < 300) begin n++; @(negedge clk); end
    check("t3_run_cycles", n, 100);
    check("t3_terr", timeout_err, 1);
    check("t3_valid", res_valid, 0);
    wait_until(2, 1'b0, 10, "t3_idle");
    check("t3_count", res_count, 2);
    pulse(0);
    check("t3_terr_cleared", timeout_err, 0);
    pulse(2);
    wait_until(2, 1'b0, 10, "t3_idle2");

    // 4: abort 3 cycles into RUN
    pulse(0);
    pulse(1);
    wait_until(0, 1'b1, 10, "t4_run");
    cyc(3);
    pulse(2);
    check("t4_state", state_dbg, 5);
    check("t4_init", proc_init, 0);
    check("t4_freeze", cap_freeze, 0);
    wait_until(2, 1'b0, 10, "t4_idle");
    check("t4_count", res_count, 2);

    // 5: continuous mode, three frames from a fresh reset
    rst = 1'b1; cyc(2); rst = 1'b0;
    cmd_continuous = 1'b1; proc_color = 2'd1; proc_figure = 2'd2;
    pulse(0);
    mon_en = 1;
    for (int f = 0; f < 3; f++) begin
      wait_until(4, 1'b1, 10, "t5_wait_frame");
      pulse(1);
      wait_until(0, 1'b1, 10, "t5_run");
      cyc(5);
      proc_done = 1'b1;
      wait_until(1, 1'b1, 5, "t5_res_new");
      proc_done = 1'b0;
    end
    wait_until(4, 1'b1, 10, "t5_back_to_wait");
    mon_en = 0;
    cmd_continuous = 1'b0;
    check("t5_count", res_count, 3);
    check("t5_busy_low", busy_low, 0);
    check("t5_gap_ge2", (min_gap >= 2 && min_gap < 1000), 1);
    pulse(2);
    wait_until(2, 1'b0, 10, "t5_idle");

    // 6: start with coincident frame pulse, then reset mid-pass
    cmd_start = 1'b1; cap_frame_done = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cap_frame_done = 1'b0;
    cyc(5);
    check("t6_still_waiting", state_dbg, 1);
    pulse(1);
    check("t6_freeze", state_dbg, 2);
    wait_until(0, 1'b1, 10, "t6_run");
    cyc(2);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_init", proc_init, 0);
    check("t6_rst_freeze", cap_freeze, 0);
    check("t6_rst_count", res_count, 0);
    rst = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
